// File: rtl/restoring_divider32_pkg.sv
// Shared types and constants for the 32-bit restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

    localparam int DIV_WIDTH  = 32;
    localparam int DIV_ITER_W = 5;

    // Counter value on the final (32nd) quotient-bit iteration.
    localparam logic [DIV_ITER_W-1:0] DIV_LAST_ITER = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZERO = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Two's-complement negate when neg is set; used for magnitude and sign fix-up.
    function automatic logic [DIV_WIDTH-1:0] cond_neg(input logic [DIV_WIDTH-1:0] x,
                                                      input logic                 neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/restoring_divider32_if.sv
// Request/response bundle between the execute stage and the divider.
// Latency: n/a (wires only).
// Backpressure: none; the requester stalls on busy until data_resultRDY.
interface restoring_divider32_if;
    import div_pkg::*;

    logic                 ctrl_div;
    logic [DIV_WIDTH-1:0] data_operandA;
    logic [DIV_WIDTH-1:0] data_operandB;
    logic [DIV_WIDTH-1:0] data_result;
    logic [DIV_WIDTH-1:0] data_remainder;
    logic                 data_exception;
    logic                 data_resultRDY;
    logic                 busy;

    modport master (
        output ctrl_div, data_operandA, data_operandB,
        input  data_result, data_remainder, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_div, data_operandA, data_operandB,
        output data_result, data_remainder, data_exception, data_resultRDY, busy
    );

endinterface

// File: rtl/restoring_divider32_sub33.sv
// 33-bit trial subtractor (a - b as a + ~b + 1) with borrow-out.
// Latency: combinational.
// Backpressure: n/a.
module sub33 (
    input  logic [32:0] a,
    input  logic [32:0] b,
    output logic [32:0] diff,
    output logic        borrow
);

    logic [33:0] sum;

    // Carry-out of a + ~b + 1 is set exactly when a >= b, so borrow is its inverse.
    always_comb begin
        sum    = {1'b0, a} + {1'b0, ~b} + 34'd1;
        diff   = sum[32:0];
        borrow = ~sum[33];
    end

endmodule

// File: rtl/restoring_divider32.sv
// Multicycle restoring divider, one quotient bit per clock; DIV_SIGNED_EN selects signed mode.
// Latency: 33 cycles start-to-resultRDY (2 for divide-by-zero); back-to-back starts from DONE.
// Backpressure: none; ctrl_div is ignored while busy, the pipeline stalls on busy.
import div_pkg::*;

module restoring_divider32 #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    restoring_divider32_if.slave  bus
);

    div_state_e             state_q, state_d;
    logic [WIDTH-1:0]       rem_q, rem_d;
    logic [WIDTH-1:0]       quo_q, quo_d;
    logic [WIDTH-1:0]       dvsr_q, dvsr_d;
    logic [DIV_ITER_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic [WIDTH-1:0]       remainder_q, remainder_d;
    logic                   exc_q, exc_d;
    logic                   rdy_q, rdy_d;
    logic                   busy_q, busy_d;
`ifdef DIV_SIGNED_EN
    logic                   neg_quo_q, neg_quo_d;
    logic                   neg_rem_q, neg_rem_d;
    logic                   ovf_q, ovf_d;
`endif

    logic [WIDTH:0]         trial_a;
    logic [WIDTH:0]         trial_diff;
    logic                   trial_borrow;
    logic [WIDTH-1:0]       rem_step, quo_step;
    logic [WIDTH-1:0]       op_a_mag, op_b_mag;
    logic [WIDTH-1:0]       res_fix, rem_fix;
    logic                   exc_fin;
    logic                   unused_diff_msb;

    // Shifted partial remainder: {R, Q} << 1 exposes {R, Q[msb]} for the trial subtract.
    always_comb begin
        trial_a = {rem_q, quo_q[WIDTH-1]};
    end

    sub33 u_sub33 (
        .a      (trial_a),
        .b      ({1'b0, dvsr_q}),
        .diff   (trial_diff),
        .borrow (trial_borrow)
    );

    // Keep the difference on no-borrow, otherwise restore the shifted remainder.
    // A kept difference is always below the divisor, so its top bit is never needed.
    always_comb begin
        rem_step        = trial_borrow ? trial_a[WIDTH-1:0] : trial_diff[WIDTH-1:0];
        quo_step        = {quo_q[WIDTH-2:0], ~trial_borrow};
        unused_diff_msb = trial_diff[WIDTH];
    end

    // Operand magnitudes and final sign fix-up (identity in the unsigned build).
    always_comb begin
`ifdef DIV_SIGNED_EN
        op_a_mag = cond_neg(bus.data_operandA, bus.data_operandA[WIDTH-1]);
        op_b_mag = cond_neg(bus.data_operandB, bus.data_operandB[WIDTH-1]);
        res_fix  = cond_neg(quo_step, neg_quo_q);
        rem_fix  = cond_neg(rem_step, neg_rem_q);
        exc_fin  = ovf_q;
`else
        op_a_mag = bus.data_operandA;
        op_b_mag = bus.data_operandB;
        res_fix  = quo_step;
        rem_fix  = rem_step;
        exc_fin  = 1'b0;
`endif
    end

    // Next-state and next-output logic for the IDLE/RUN/ZERO/DONE controller.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        exc_d       = exc_q;
`ifdef DIV_SIGNED_EN
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        ovf_d       = ovf_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (bus.ctrl_div) begin
                    dvsr_d = op_b_mag;
                    rem_d  = '0;
                    quo_d  = op_a_mag;
                    cnt_d  = '0;
`ifdef DIV_SIGNED_EN
                    neg_quo_d = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                    neg_rem_d = bus.data_operandA[WIDTH-1];
                    ovf_d     = (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                                (bus.data_operandB == {WIDTH{1'b1}});
`endif
                    state_d = (bus.data_operandB == '0) ? ZERO : RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == DIV_LAST_ITER) begin
                    state_d     = DONE;
                    result_d    = res_fix;
                    remainder_d = rem_fix;
                    exc_d       = exc_fin;
                end
            end
            ZERO: begin
                state_d     = DONE;
                result_d    = '0;
                remainder_d = '0;
                exc_d       = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        rdy_d  = (state_d == DONE);
        busy_d = (state_d == RUN) || (state_d == ZERO);
    end

    // State and output registers; reset discards any in-flight operation.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            remainder_q <= '0;
            exc_q       <= 1'b0;
            rdy_q       <= 1'b0;
            busy_q      <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            exc_q       <= exc_d;
            rdy_q       <= rdy_d;
            busy_q      <= busy_d;
`ifdef DIV_SIGNED_EN
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_remainder = remainder_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = busy_q;

endmodule

// File: tb/tb_restoring_divider32.sv
// Scoreboard bench for restoring_divider32: directed spec cases plus random operands.
// Latency: completion cycle is checked against E0+32 (E0+1 for divide-by-zero).
// Backpressure: none; stimulus waits for the scoreboard to drain between operations.
module tb_restoring_divider32;
    import div_pkg::*;

    logic clock = 1'b0;
    logic reset;

    restoring_divider32_if dif ();

    restoring_divider32 #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (dif)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        exc;
        int unsigned cyc;
    } exp_t;

    exp_t        scb[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Reference: plain arithmetic on the operand values.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.cyc = 0;
        if (b == 32'd0) begin
            e.q = 32'd0; e.r = 32'd0; e.exc = 1'b1;
        end
`ifdef DIV_SIGNED_EN
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000; e.r = 32'd0; e.exc = 1'b1;
        end else begin
            int sa, sd;
            sa = a; sd = b;
            e.q = sa / sd; e.r = sa % sd; e.exc = 1'b0;
        end
`else
        else begin
            e.q = a / b; e.r = a % b; e.exc = 1'b0;
        end
`endif
        return e;
    endfunction

    // Monitor: every completion pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (dif.data_resultRDY === 1'b1) begin
            exp_t e;
            if (scb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rdy: resultRDY=1 at cycle %0d, required 0", cyc);
            end else begin
                e = scb.pop_front();
                check("result", dif.data_result, e.q);
                check("remainder", dif.data_remainder, e.r);
                check("exception", {31'd0, dif.data_exception}, {31'd0, e.exc});
                check("rdy_cycle", cyc, e.cyc);
            end
        end
    end

    // Start one operation; expected completion is E0+32, or E0+1 when the divisor is zero.
    task automatic issue_exp(input logic [31:0] a, input logic [31:0] b, input exp_t e,
                             input logic push);
        @(negedge clock);
        dif.data_operandA = a;
        dif.data_operandB = b;
        dif.ctrl_div      = 1'b1;
        @(posedge clock);
        #1;
        dif.ctrl_div      = 1'b0;
        dif.data_operandA = $urandom;
        dif.data_operandB = $urandom;
        if (push) begin
            e.cyc = cyc + ((b == 32'd0) ? 1 : 32);
            scb.push_back(e);
        end
    endtask

    task automatic issue_rand(input logic [31:0] a, input logic [31:0] b);
        issue_exp(a, b, model(a, b), 1'b1);
    endtask

    task automatic count_busy(input int req);
        int bc;
        bc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (dif.busy === 1'b1) bc++;
            if (dif.data_resultRDY === 1'b1) break;
        end
        check("busy_cycles", bc, req);
    endtask

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        while (scb.size() != 0 && i < budget) begin
            @(negedge clock);
            #1;
            i++;
        end
        n_checks++;
        if (scb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", scb.size());
            scb.delete();
        end
    endtask

    function automatic exp_t mk(input logic [31:0] q, input logic [31:0] r, input logic exc);
        exp_t e;
        e.q = q; e.r = r; e.exc = exc; e.cyc = 0;
        return e;
    endfunction

    initial begin
        logic [31:0] a, b;
        int unsigned c0;

        reset             = 1'b1;
        dif.ctrl_div      = 1'b0;
        dif.data_operandA = 32'd0;
        dif.data_operandB = 32'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_result", dif.data_result, 32'd0);
        check("rst_remainder", dif.data_remainder, 32'd0);
        check("rst_exception", {31'd0, dif.data_exception}, 32'd0);
        check("rst_rdy", {31'd0, dif.data_resultRDY}, 32'd0);
        check("rst_busy", {31'd0, dif.busy}, 32'd0);
        reset = 1'b0;

        // Directed cases from the test plan.
        issue_exp(32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0), 1'b1);
        count_busy(32);
        wait_drain(100);

        issue_exp(32'h1234, 32'd0, mk(32'd0, 32'd0, 1'b1), 1'b1);
        count_busy(1);
        wait_drain(100);

`ifdef DIV_SIGNED_EN
        issue_exp(32'hFFFF_FFF9, 32'd2, mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0), 1'b1);
        wait_drain(100);
        issue_exp(32'h8000_0000, 32'hFFFF_FFFF, mk(32'h8000_0000, 32'd0, 1'b1), 1'b1);
        wait_drain(100);
        issue_exp(32'd100, 32'hFFFF_FFF9, mk(32'hFFFF_FFF2, 32'd2, 1'b0), 1'b1);
        wait_drain(100);
`else
        issue_exp(32'hFFFF_FFFF, 32'h10, mk(32'h0FFF_FFFF, 32'hF, 1'b0), 1'b1);
        wait_drain(100);
        issue_exp(32'd5, 32'hFFFF_FFFF, mk(32'd0, 32'd5, 1'b0), 1'b1);
        wait_drain(100);
`endif

        // Random operands against the arithmetic model.
        for (int n = 0; n < 24; n++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 16);
                2:       b = $urandom;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 1) == 0) a = a >> $urandom_range(0, 31);
            issue_rand(a, b);
            wait_drain(100);
        end

        // ctrl_div held high: second operation starts from DONE with no lost cycle.
        @(negedge clock);
        dif.data_operandA = 32'd50;
        dif.data_operandB = 32'd5;
        dif.ctrl_div      = 1'b1;
        @(posedge clock);
        #1;
        c0 = cyc;
        scb.push_back('{q: 32'd10, r: 32'd0, exc: 1'b0, cyc: c0 + 32});
        repeat (32) @(posedge clock);
        @(negedge clock);
        dif.data_operandA = 32'd9;
        dif.data_operandB = 32'd4;
        scb.push_back('{q: 32'd2, r: 32'd1, exc: 1'b0, cyc: c0 + 65});
        @(posedge clock);
        #1;
        dif.ctrl_div = 1'b0;
        wait_drain(100);

        // Start ignored mid-run, then reset aborts: no completion, all outputs cleared.
        issue_exp(32'd1000, 32'd3, mk(32'd0, 32'd0, 1'b0), 1'b0);
        repeat (9) @(posedge clock);
        @(negedge clock);
        dif.data_operandA = 32'd5;
        dif.data_operandB = 32'd5;
        dif.ctrl_div      = 1'b1;
        @(posedge clock);
        #1;
        dif.ctrl_div = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock);
        check("mid_run_busy", {31'd0, dif.busy}, 32'd1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("abort_result", dif.data_result, 32'd0);
        check("abort_remainder", dif.data_remainder, 32'd0);
        check("abort_exception", {31'd0, dif.data_exception}, 32'd0);
        check("abort_rdy", {31'd0, dif.data_resultRDY}, 32'd0);
        check("abort_busy", {31'd0, dif.busy}, 32'd0);
        reset = 1'b0;
        repeat (60) @(posedge clock);
        @(negedge clock);
        check("post_abort_busy", {31'd0, dif.busy}, 32'd0);

        // Recovery after reset.
        issue_exp(32'd1000, 32'd3, mk(32'd333, 32'd1, 1'b0), 1'b1);
        wait_drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/restoring_divider32.md
# restoring_divider32

Multicycle 32-bit restoring divider for the processor's integer datapath; the subtracting counterpart of the existing 32-bit ripple adder. One quotient bit is produced per clock by trial subtraction of the divisor from the partial remainder. It sits beside the ALU in the execute stage, and the pipeline stalls on `busy` until `data_resultRDY` pulses.

## Interface
- `WIDTH`, 32: operand and result width. Only 32 is supported.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `ctrl_div` in 1: start request; sampled on a rising edge.
- `data_operandA` in 32: dividend; sampled on the start edge only.
- `data_operandB` in 32: divisor; sampled on the start edge only.
- `data_result` out 32: quotient; registered.
- `data_remainder` out 32: remainder; registered.
- `data_exception` out 1: divide-by-zero, or signed overflow when signed mode is compiled in.
- `data_resultRDY` out 1: one-cycle completion pulse.
- `busy` out 1: high in RUN and ZERO states.

## Operation
- States:
  - IDLE: `ctrl_div`=1 goes to RUN, or to ZERO if the divisor is 0.
  - RUN: performs 32 iterations, then goes to DONE.
  - ZERO: goes to DONE on the next edge.
  - DONE: goes to IDLE, or to RUN/ZERO if `ctrl_div`=1.
- Start edge (E0):
  - Latch the divisor magnitude.
  - Load {R=0, Q=dividend magnitude}.
  - Clear the 5-bit iteration counter.
- Each RUN edge:
  - Shift {R,Q} left by 1.
  - Compute D = R_shifted − divisor as a 33-bit subtraction.
  - If D is non-negative (no borrow): R = D and Q[0] = 1. Otherwise restore R and set Q[0] = 0.
- On the 32nd RUN edge: load `data_result`/`data_remainder` from Q/R after any sign fix-up, and clear `data_exception`.
- ZERO path:
  - `data_result` = 0, `data_remainder` = 0.
  - `data_exception` = 1.
- `ctrl_div` in RUN or ZERO is ignored; the operation is neither restarted nor queued.
- `ctrl_div` in DONE is accepted on that edge. `data_resultRDY` is still high for that cycle, so back-to-back operations lose no cycle.
- Outputs hold their last values until the next completion load.
- Reset in any state:
  - Go to IDLE.
  - All outputs to 0: `data_result`, `data_remainder`, `data_exception`, `data_resultRDY`, `busy`.
  - An in-flight result is discarded and no `data_resultRDY` is produced.

## Timing
- `data_resultRDY` = (state == DONE), one cycle wide.
- Normal latency: start at edge E0, iterations on E1–E32, DONE entered at E32. `data_resultRDY` is high in the cycle between E32 and E33.
- Divide-by-zero latency: ZERO entered at E0, DONE at E1. `data_resultRDY` is high between E1 and E2.
- `busy` is high from after E0 until DONE is entered.
- Result registers are valid in the same cycle that `data_resultRDY` is high.

## Configuration
- `DIV_SIGNED_EN` defined (signed two's-complement mode):
  - Operands are converted to magnitudes at E0.
  - The quotient is negated if the operand signs differ, truncating toward zero.
  - The remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF: `data_exception`=1, `data_result`=0x80000000, `data_remainder`=0, normal 33-cycle latency.
- `DIV_SIGNED_EN` undefined: operands are unsigned, no magnitude or sign logic is built, and only divide-by-zero raises `data_exception`.

## Structure
- `div_pkg` contains:
  - The state enum (IDLE, RUN, ZERO, DONE).
  - `DIV_WIDTH`=32.
  - `DIV_ITER_W`=5.
  - The last-iteration constant 31.
- Sub-module `sub33`: combinational 33-bit trial subtractor (A + ~B + 1) with outputs `diff[32:0]` and `borrow`. One instance only.

## Test plan
- 100 / 7 → `data_result`=14, `data_remainder`=2, `data_exception`=0. `data_resultRDY` high only in the cycle after E32, `busy` high for exactly 32 cycles.
- 0x1234 / 0 → `data_exception`=1, `data_result`=0, `data_remainder`=0. `data_resultRDY` in the cycle after E1.
- Unsigned build, 0xFFFFFFFF / 0x10 → `data_result`=0x0FFFFFFF, `data_remainder`=0xF. Signed build, −7 / 2 → `data_result`=0xFFFFFFFD, `data_remainder`=0xFFFFFFFF.
- Signed build, 0x80000000 / 0xFFFFFFFF → `data_exception`=1, `data_result`=0x80000000, `data_remainder`=0.
- Start 1000/3, pulse `ctrl_div` with 5/5 at iteration 10, then assert `reset` at iteration 20 → the second start is ignored; all outputs and `busy` are 0 the cycle after reset; no `data_resultRDY`.
- `ctrl_div` held high across two operations, 50/5 then 9/4 → results 10 r0 then 2 r1. The second `data_resultRDY` arrives exactly 33 cycles after the first.
